// File: rtl/hermes_switch_control.sv
// ----------------------------------------------------------------------------
// hermes_switch_control
//
// Routing and arbitration controller for one Hermes router. Input buffers
// raise a header request; one requester per round is picked round-robin. The
// XY route is computed from the head flit and checked against the turn rules
// and the free mask. A legal request for a free output programs the crossbar
// select tables. A connection is torn down when its input finishes sending.
//
// Port index encoding: 0=E, 1=W, 2=N, 3=S, 4=L. Any tab value >= 5 (3'b111 is
// the one produced here) means "no connection".
//
// Ports:
//   clock      rising-edge clock
//   reset_n    synchronous active-low reset
//   h          per input: header flit waiting at buffer head
//   header     head flit of each input, port p at [p*FLIT_W +: FLIT_W]
//   sender     per input: packet transfer in progress
//   ack_h      one-cycle header accept pulse to the granted input
//   free       per output: 1 = unallocated
//   tab_in     per input, 3-bit output index it drives (3'b111 = none)
//   tab_out    per output, 3-bit input index feeding it (3'b111 = none)
//   route_err  one-cycle pulse: header requested an illegal turn
// ----------------------------------------------------------------------------
module hermes_switch_control #(
  parameter logic [3:0] ADDR_X = 4'd0,
  parameter logic [3:0] ADDR_Y = 4'd0,
  parameter int         FLIT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4:0]            h,
  input  logic [5*FLIT_W-1:0]   header,
  input  logic [4:0]            sender,
  output logic [4:0]            ack_h,
  output logic [4:0]            free,
  output logic [14:0]           tab_in,
  output logic [14:0]           tab_out,
  output logic                  route_err
);

  localparam logic [2:0] PORT_E    = 3'd0;
  localparam logic [2:0] PORT_W    = 3'd1;
  localparam logic [2:0] PORT_N    = 3'd2;
  localparam logic [2:0] PORT_S    = 3'd3;
  localparam logic [2:0] PORT_L    = 3'd4;
  localparam logic [2:0] PORT_NONE = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] tgt_q, tgt_d;
  logic [2:0] dest_q, dest_d;
  logic [4:0] sender_q;
  logic [4:0] ack_h_q, ack_h_d;
  logic       route_err_q, route_err_d;
  logic [4:0] free_q, free_d;
  logic [2:0] tab_in_q [5];
  logic [2:0] tab_in_d [5];
  logic [2:0] tab_out_q [5];
  logic [2:0] tab_out_d [5];

  logic [4:0] cand;
  logic [4:0] fall;
  logic [7:0] hdr_tgt [5];
  logic       found;
  logic [2:0] pick;
  logic [3:0] idx;
  logic [2:0] route_dest;
  logic       illegal;

  // Target address field of every head flit.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      hdr_tgt[p] = header[p*FLIT_W +: 8];
    end
  end

  // A port competes only while it has a header and is not already sending.
  assign cand = h & ~sender;
  assign fall = sender_q & ~sender;

  // Round-robin search starting just after the last selected port.
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      idx = 4'(ptr_q) + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = 3'(idx);
      end
    end
  end

  // XY routing: resolve X first, then Y, then deliver locally.
  always_comb begin
    if (tgt_q[7:4] > ADDR_X)      route_dest = PORT_E;
    else if (tgt_q[7:4] < ADDR_X) route_dest = PORT_W;
    else if (tgt_q[3:0] > ADDR_Y) route_dest = PORT_N;
    else if (tgt_q[3:0] < ADDR_Y) route_dest = PORT_S;
    else                          route_dest = PORT_L;
    // U-turns and Y-to-X turns are forbidden under XY routing.
    illegal = (route_dest == sel_q) ||
              (((sel_q == PORT_N) || (sel_q == PORT_S)) &&
               ((route_dest == PORT_E) || (route_dest == PORT_W)));
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    tgt_d       = tgt_q;
    dest_d      = dest_q;
    ack_h_d     = '0;
    route_err_d = 1'b0;
    free_d      = free_q;
    tab_in_d    = tab_in_q;
    tab_out_d   = tab_out_q;

    // Release runs every cycle. It is applied before the grant so that a grant
    // in the same cycle (always to a different output) also takes effect.
    for (int i = 0; i < 5; i++) begin
      if (fall[i] && (tab_in_q[i] < 3'd5)) begin
        free_d[tab_in_q[i]]    = 1'b1;
        tab_out_d[tab_in_q[i]] = PORT_NONE;
        tab_in_d[i]            = PORT_NONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cand != '0) state_d = S_ARB;
      end
      S_ARB: begin
        if (found) begin
          sel_d   = pick;
          tgt_d   = hdr_tgt[pick];
          // The pointer advances even if the grant later fails, so a blocked
          // port waits behind the others instead of hogging the arbiter.
          ptr_d   = pick;
          state_d = S_ROUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUTE: begin
        dest_d = route_dest;
        if (illegal) begin
          route_err_d = 1'b1;
          state_d     = S_IDLE;
        end else if (!free_q[route_dest]) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        ack_h_d[sel_q]    = 1'b1;
        free_d[dest_q]    = 1'b0;
        tab_in_d[sel_q]   = dest_q;
        tab_out_d[dest_q] = sel_q;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= PORT_L;
      sel_q       <= PORT_E;
      tgt_q       <= '0;
      dest_q      <= PORT_E;
      sender_q    <= '0;
      ack_h_q     <= '0;
      route_err_q <= 1'b0;
      free_q      <= '1;
      // NOTE: the select tables are live connection state rather than bulk
      // storage, so they must be reset to drop every connection.
      for (int p = 0; p < 5; p++) begin
        tab_in_q[p]  <= PORT_NONE;
        tab_out_q[p] <= PORT_NONE;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      tgt_q       <= tgt_d;
      dest_q      <= dest_d;
      sender_q    <= sender;
      ack_h_q     <= ack_h_d;
      route_err_q <= route_err_d;
      free_q      <= free_d;
      tab_in_q    <= tab_in_d;
      tab_out_q   <= tab_out_d;
    end
  end

  assign ack_h     = ack_h_q;
  assign free      = free_q;
  assign route_err = route_err_q;

  for (genvar g = 0; g < 5; g++) begin : g_tab
    assign tab_in[3*g +: 3]  = tab_in_q[g];
    assign tab_out[3*g +: 3] = tab_out_q[g];
  end

endmodule

// File: tb/tb_hermes_switch_control.sv
// ----------------------------------------------------------------------------
// tb_hermes_switch_control
//
// Bench for hermes_switch_control at router address (1,1). Expected grants
// (input, output) are queued when requests are raised and popped when ack_h
// pulses. The bench plays the input buffers: on ack it drops h and raises
// sender for the granted port.
// ----------------------------------------------------------------------------
module tb_hermes_switch_control;

  localparam int FLIT_W = 16;

  typedef struct packed {
    logic [2:0] port;
    logic [2:0] dest;
  } grant_t;

  logic                clock;
  logic                reset_n;
  logic [4:0]          h;
  logic [5*FLIT_W-1:0] header;
  logic [4:0]          sender;
  logic [4:0]          ack_h;
  logic [4:0]          free;
  logic [14:0]         tab_in;
  logic [14:0]         tab_out;
  logic                route_err;

  int     checks = 0;
  int     errors = 0;
  grant_t exp_q[$];

  hermes_switch_control #(
    .ADDR_X(4'd1),
    .ADDR_Y(4'd1),
    .FLIT_W(FLIT_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .h        (h),
    .header   (header),
    .sender   (sender),
    .ack_h    (ack_h),
    .free     (free),
    .tab_in   (tab_in),
    .tab_out  (tab_out),
    .route_err(route_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [2:0] fld(input logic [14:0] v, input int i);
    return v[i*3 +: 3];
  endfunction

  task automatic set_hdr(input int p, input logic [7:0] tgt);
    header[p*FLIT_W +: FLIT_W] = {8'h00, tgt};
  endtask

  // Wait (bounded) for an ack_h pulse; counts falling edges until seen.
  task automatic wait_ack(input int budget, output logic [4:0] seen, output int cycles);
    cycles = 0;
    seen   = '0;
    while (cycles < budget && seen == '0) begin
      @(negedge clock);
      cycles++;
      seen = ack_h;
    end
  endtask

  task automatic test_reset();
    checks++; if (ack_h !== 5'b00000) begin errors++; $display("FAIL reset_ack: got %b want 00000", ack_h); end
    checks++; if (free !== 5'b11111) begin errors++; $display("FAIL reset_free: got %b want 11111", free); end
    checks++; if (tab_in !== 15'h7fff) begin errors++; $display("FAIL reset_tab_in: got %h want 7fff", tab_in); end
    checks++; if (tab_out !== 15'h7fff) begin errors++; $display("FAIL reset_tab_out: got %h want 7fff", tab_out); end
    checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL reset_route_err: got %b want 0", route_err); end
  endtask

  // Local input targets (2,1): route east, ack three edges after the request.
  task automatic test_single_grant();
    logic [4:0] seen;
    int         cyc;
    grant_t     e;
    set_hdr(4, 8'h21);
    h[4] = 1'b1;
    exp_q.push_back('{port: 3'd4, dest: 3'd0});
    wait_ack(12, seen, cyc);
    e = exp_q.pop_front();
    checks++; if (seen !== 5'(1) << e.port) begin errors++; $display("FAIL single_ack: got %b want %b", seen, 5'(1) << e.port); end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL single_latency: got %0d want 4", cyc); end
    checks++; if (free !== 5'b11110) begin errors++; $display("FAIL single_free: got %b want 11110", free); end
    checks++; if (fld(tab_out, 0) !== e.port) begin errors++; $display("FAIL single_tab_out_e: got %0d want %0d", fld(tab_out, 0), e.port); end
    checks++; if (fld(tab_in, 4) !== e.dest) begin errors++; $display("FAIL single_tab_in_l: got %0d want %0d", fld(tab_in, 4), e.dest); end
    h[4] = 1'b0;
    sender[4] = 1'b1;
    @(negedge clock);
    checks++; if (ack_h !== 5'b00000) begin errors++; $display("FAIL single_ack_width: got %b want 00000", ack_h); end
  endtask

  task automatic test_release();
    repeat (2) @(negedge clock);
    checks++; if (free !== 5'b11110) begin errors++; $display("FAIL release_hold: got %b want 11110", free); end
    sender[4] = 1'b0;
    @(negedge clock);
    checks++; if (free !== 5'b11111) begin errors++; $display("FAIL release_free: got %b want 11111", free); end
    checks++; if (fld(tab_out, 0) !== 3'd7) begin errors++; $display("FAIL release_tab_out_e: got %0d want 7", fld(tab_out, 0)); end
    checks++; if (fld(tab_in, 4) !== 3'd7) begin errors++; $display("FAIL release_tab_in_l: got %0d want 7", fld(tab_in, 4)); end
  endtask

  // E and W both want L; E wins (ptr=L), W waits until E's packet ends.
  task automatic test_round_robin();
    logic [4:0] seen;
    int         cyc;
    int         acks;
    grant_t     e;
    set_hdr(0, 8'h11);
    set_hdr(1, 8'h11);
    h[1:0] = 2'b11;
    exp_q.push_back('{port: 3'd0, dest: 3'd4});
    wait_ack(12, seen, cyc);
    e = exp_q.pop_front();
    checks++; if (seen !== 5'(1) << e.port) begin errors++; $display("FAIL rr_first_ack: got %b want %b", seen, 5'(1) << e.port); end
    checks++; if (fld(tab_out, 4) !== e.port) begin errors++; $display("FAIL rr_first_tab_out_l: got %0d want %0d", fld(tab_out, 4), e.port); end
    h[0] = 1'b0;
    sender[0] = 1'b1;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (ack_h != '0) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rr_blocked_acks: got %0d want 0", acks); end
    checks++; if (fld(tab_out, 4) !== 3'd0) begin errors++; $display("FAIL rr_blocked_tab_out_l: got %0d want 0", fld(tab_out, 4)); end
    sender[0] = 1'b0;
    exp_q.push_back('{port: 3'd1, dest: 3'd4});
    wait_ack(20, seen, cyc);
    e = exp_q.pop_front();
    checks++; if (seen !== 5'(1) << e.port) begin errors++; $display("FAIL rr_second_ack: got %b want %b", seen, 5'(1) << e.port); end
    checks++; if (fld(tab_out, 4) !== e.port) begin errors++; $display("FAIL rr_second_tab_out_l: got %0d want %0d", fld(tab_out, 4), e.port); end
    checks++; if (fld(tab_in, 1) !== e.dest) begin errors++; $display("FAIL rr_second_tab_in_w: got %0d want %0d", fld(tab_in, 1), e.dest); end
    h[1] = 1'b0;
    sender[1] = 1'b1;
    repeat (2) @(negedge clock);
    sender[1] = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (free !== 5'b11111) begin errors++; $display("FAIL rr_final_free: got %b want 11111", free); end
  endtask

  // N input heading to (2,1) needs a Y-to-X turn: rejected.
  task automatic test_route_err();
    int pulses;
    int first;
    int acks;
    pulses = 0;
    first  = 0;
    acks   = 0;
    set_hdr(2, 8'h21);
    h[2] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (ack_h != '0) acks++;
      if (route_err) begin
        pulses++;
        if (first == 0) first = i;
        h[2] = 1'b0;
      end
    end
    h[2] = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL route_err_pulses: got %0d want 1", pulses); end
    checks++; if (first !== 3) begin errors++; $display("FAIL route_err_latency: got %0d want 3", first); end
    checks++; if (acks !== 0) begin errors++; $display("FAIL route_err_acks: got %0d want 0", acks); end
    checks++; if (free !== 5'b11111) begin errors++; $display("FAIL route_err_free: got %b want 11111", free); end
  endtask

  // Four legal requests to distinct outputs; ptr is N, so order is S,L,E,W.
  task automatic test_back_to_back();
    logic [4:0] seen;
    int         cyc;
    grant_t     e;
    set_hdr(0, 8'h01);
    set_hdr(1, 8'h21);
    set_hdr(3, 8'h11);
    set_hdr(4, 8'h12);
    h = 5'b11011;
    exp_q.push_back('{port: 3'd3, dest: 3'd4});
    exp_q.push_back('{port: 3'd4, dest: 3'd2});
    exp_q.push_back('{port: 3'd0, dest: 3'd1});
    exp_q.push_back('{port: 3'd1, dest: 3'd0});
    for (int g = 0; g < 4; g++) begin
      wait_ack(12, seen, cyc);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b2b_queue_empty: grant %0d got %b want none", g, seen);
      end else begin
        e = exp_q.pop_front();
        checks++; if (seen !== 5'(1) << e.port) begin errors++; $display("FAIL b2b_ack_%0d: got %b want %b", g, seen, 5'(1) << e.port); end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d want 4", g, cyc); end
        checks++; if (fld(tab_in, int'(e.port)) !== e.dest) begin errors++; $display("FAIL b2b_tab_in_%0d: got %0d want %0d", g, fld(tab_in, int'(e.port)), e.dest); end
        checks++; if (fld(tab_out, int'(e.dest)) !== e.port) begin errors++; $display("FAIL b2b_tab_out_%0d: got %0d want %0d", g, fld(tab_out, int'(e.dest)), e.port); end
        checks++; if (free[e.dest] !== 1'b0) begin errors++; $display("FAIL b2b_free_%0d: got %b want 0", g, free[e.dest]); end
        h[e.port] = 1'b0;
        sender[e.port] = 1'b1;
      end
    end
    @(negedge clock);
    checks++; if (free !== 5'b01000) begin errors++; $display("FAIL b2b_final_free: got %b want 01000", free); end
  endtask

  // Reset while connections are live, then confirm IDLE and ptr=L (E first).
  task automatic test_reset_mid_packet();
    logic [4:0] seen;
    int         cyc;
    grant_t     e;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    sender  = '0;
    checks++; if (free !== 5'b11111) begin errors++; $display("FAIL mid_reset_free: got %b want 11111", free); end
    checks++; if (tab_in !== 15'h7fff) begin errors++; $display("FAIL mid_reset_tab_in: got %h want 7fff", tab_in); end
    checks++; if (tab_out !== 15'h7fff) begin errors++; $display("FAIL mid_reset_tab_out: got %h want 7fff", tab_out); end
    checks++; if (ack_h !== 5'b00000) begin errors++; $display("FAIL mid_reset_ack: got %b want 00000", ack_h); end
    set_hdr(0, 8'h11);
    set_hdr(4, 8'h21);
    h = 5'b10001;
    exp_q.push_back('{port: 3'd0, dest: 3'd4});
    exp_q.push_back('{port: 3'd4, dest: 3'd0});
    for (int g = 0; g < 2; g++) begin
      wait_ack(12, seen, cyc);
      e = exp_q.pop_front();
      checks++; if (seen !== 5'(1) << e.port) begin errors++; $display("FAIL post_reset_ack_%0d: got %b want %b", g, seen, 5'(1) << e.port); end
      checks++; if (cyc !== 4) begin errors++; $display("FAIL post_reset_latency_%0d: got %0d want 4", g, cyc); end
      h[e.port] = 1'b0;
      sender[e.port] = 1'b1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    h       = '0;
    sender  = '0;
    header  = '0;
    repeat (2) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    @(negedge clock);
    test_single_grant();
    test_release();
    test_round_robin();
    test_route_err();
    test_back_to_back();
    test_reset_mid_packet();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hermes_switch_control.md
Name: hermes_switch_control

Overview:
Routing and arbitration controller for one Hermes router. It watches header-request lines from the five input buffers and picks one requester per round with round-robin priority. It computes the XY route from the header flit, checks that the output is free, then programs the crossbar select tables (tab_in/tab_out) and the free mask. It releases each connection when the owning input finishes sending its packet.

Parameters:
ADDR_X, 4'd0, router X coordinate
ADDR_Y, 4'd0, router Y coordinate
FLIT_W, 16, flit width; header target address is in bits [7:0] (X=[7:4], Y=[3:0])

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  reset, synchronous, active-low
h  in  5  per input port: header flit waiting at buffer head (index E=0,W=1,N=2,S=3,L=4)
header  in  5*FLIT_W  head flit of each input buffer, port p at [p*FLIT_W +: FLIT_W]
sender  in  5  per input port: packet transfer in progress (from input buffer)
ack_h  out  5  one-cycle header accept pulse to the granted input buffer
free  out  5  per output port: 1 = unallocated
tab_in  out  15  per input port, 3-bit output index it drives; 3'b111 = none
tab_out  out  15  per output port, 3-bit input index feeding it; 3'b111 = none
route_err  out  1  one-cycle pulse: header requested an illegal turn

Behaviour:
- Reset (reset_n=0 at edge): state=IDLE, ack_h=0, free=5'b11111, all tab_in/tab_out fields=3'b111, route_err=0, rr pointer=4 (LOCAL), so EAST has first priority.
- Port encoding: 0=E, 1=W, 2=N, 3=S, 4=L. A tab value of 3'b111 (and any value ≥5) must decode to "no connection" in the crossbar.
- FSM IDLE -> ARB -> ROUTE -> (GRANT | IDLE); all outputs are registered.
  - IDLE: if (h & ~sender) != 0, go to ARB; otherwise stay.
  - ARB:
    - Search order is ptr+1, ptr+2, … ptr+5 (mod 5); the first port with h=1 and sender=0 becomes sel.
    - Latch header[sel][7:0], then set ptr=sel whether or not the grant succeeds.
    - If no candidate remains (h dropped), go to IDLE.
  - ROUTE: compute dest with XY routing.
    - tx>ADDR_X -> E; tx<ADDR_X -> W.
    - Otherwise ty>ADDR_Y -> N; ty<ADDR_Y -> S.
    - Otherwise L.
  - ROUTE outcomes:
    - Illegal (dest==sel, or sel∈{N,S} with dest∈{E,W}): pulse route_err, no grant, go to IDLE.
    - Legal but free[dest]=0: no grant, go to IDLE; the request retries in a later round behind the other ports.
    - Legal and free[dest]=1: go to GRANT.
  - GRANT: ack_h[sel]=1 for this cycle only, free[dest]<=0, tab_in[sel]<=dest, tab_out[dest]<=sel, then go to IDLE.
- Latency: h[p] seen at edge N in IDLE with no competitors -> ack_h[p] high in cycle N+3 -> free/tab updated from edge N+3. Minimum spacing between grants is 4 cycles.
- Release (runs in every state, in parallel with the FSM):
  - Register sender_q.
  - For each input i with sender_q[i]=1 and sender[i]=0 (falling edge) and tab_in[i]=o≠7: next edge sets free[o]<=1, tab_out[o]<=7, tab_in[i]<=7.
- Simultaneous events:
  - A release and a grant on different ports in the same cycle both take effect.
  - A release cannot collide with a grant to the same output, because a grant requires free=1 already sampled in ROUTE.
  - Multiple releases in one cycle all take effect.
- A sender falling edge on a port with tab_in=7 is ignored.
- reset_n low mid-packet: all connections drop immediately to reset values; FSM returns to IDLE.
- ack_h is never asserted for more than one port or for more than one cycle.

Test Plan:
- ADDR=(1,1); single header on L with target 0x21, h[4]=1 at edge 0 -> ack_h=5'b10000 in cycle 3 only; free=5'b11110; tab_out[E]=4; tab_in[L]=0.
- Packet from test 1 finishes (sender[4] 1->0) -> one edge later free=5'b11111, tab_out[E]=7, tab_in[L]=7.
- h=5'b00011 with both targets 0x11 (local), ptr=4 -> E granted first (tab_out[L]=0); W gets no grant while L busy; after E's sender falls, W is granted (tab_out[L]=1).
- ADDR=(1,1), N input with target 0x21 -> route_err pulses one cycle, no ack_h, free unchanged.
- Four concurrent legal requests to distinct outputs (W->E, E->W, L->N, S->L) -> four grants, in round-robin order, each 4 cycles apart; free=5'b00000 after the last grant except S=1.
- reset_n=0 for one edge while two connections are active -> free=5'b11111, all tabs=7, ack_h=0, state IDLE on the next cycle.
